// File: rtl/srl_fifo8.sv
// srl_fifo8: eight-entry shift-register FIFO with valid/ready handshakes.
// Each data bit is an 8-deep addressable shift register with a common shift
// enable and a common read tap; this block owns the tap address, occupancy
// and flow control.
// Optional feature macro: SRL_FIFO8_OREG_EN adds a registered output stage
// (capacity 9, push-to-M_VALID latency 2). Default build: capacity 8, latency 1.
module srl_fifo8 #(
  parameter int unsigned DW        = 8,
  parameter int unsigned AFULL_LVL = 6
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] S_DATA,
  input  logic          S_VALID,
  output logic          S_READY,
  output logic [DW-1:0] M_DATA,
  output logic          M_VALID,
  input  logic          M_READY,
  output logic [3:0]    COUNT,
  output logic          AFULL
);

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned CW    = 4;

  // Shift storage: tap k holds the word pushed k pushes ago
  logic [DW-1:0] mem_q [DEPTH];

  logic [CW-1:0] st_cnt_q, st_cnt_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic          s_ready_q, s_ready_d;
  logic          afull_q, afull_d;
  logic          st_push_c;
  logic          st_pop_c;
  logic [DW-1:0] tap_c;

  assign st_push_c = S_VALID & s_ready_q;
  assign tap_c     = mem_q[rd_addr_q];

`ifdef SRL_FIFO8_OREG_EN
  logic          oreg_vld_q, oreg_vld_d;
  logic [DW-1:0] oreg_data_q;

  // Refill the output stage whenever it is empty or being drained
  assign st_pop_c   = (st_cnt_q != CW'(0)) & (~oreg_vld_q | M_READY);
  assign oreg_vld_d = st_pop_c | (oreg_vld_q & ~M_READY);

  // Output stage register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      oreg_vld_q  <= 1'b0;
      oreg_data_q <= '0;
    end else begin
      oreg_vld_q <= oreg_vld_d;
      if (st_pop_c) begin
        oreg_data_q <= tap_c;
      end
    end
  end

  assign count_d = st_cnt_d + CW'(oreg_vld_d);
  assign M_VALID = oreg_vld_q;
  assign M_DATA  = oreg_data_q;
`else
  logic m_valid_q, m_valid_d;

  assign st_pop_c  = (st_cnt_q != CW'(0)) & M_READY;
  assign m_valid_d = (st_cnt_d != CW'(0));

  // Registered valid flag, mirrors occupancy != 0
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_valid_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
    end
  end

  assign count_d = st_cnt_d;
  assign M_VALID = m_valid_q;
  assign M_DATA  = tap_c;
`endif

  // Storage shift on push; contents are not reset
  always_ff @(posedge CLK) begin
    if (st_push_c) begin
      mem_q[0] <= S_DATA;
      for (int k = 1; k < DEPTH; k++) begin
        mem_q[k] <= mem_q[k-1];
      end
    end
  end

  // Storage occupancy and read tap next state
  always_comb begin
    st_cnt_d  = st_cnt_q;
    rd_addr_d = rd_addr_q;
    case ({st_push_c, st_pop_c})
      2'b10: begin
        st_cnt_d  = st_cnt_q + CW'(1);
        rd_addr_d = (st_cnt_q == CW'(0)) ? AW'(0) : rd_addr_q + AW'(1);
      end
      2'b01: begin
        st_cnt_d  = st_cnt_q - CW'(1);
        rd_addr_d = rd_addr_q - AW'(1);
      end
      default: begin
        st_cnt_d  = st_cnt_q;
        rd_addr_d = rd_addr_q;
      end
    endcase
  end

  // Flow control flags derived from next-state occupancy
  assign s_ready_d = (st_cnt_d != CW'(DEPTH));
  assign afull_d   = (count_d >= CW'(AFULL_LVL));

  // Control registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_cnt_q  <= '0;
      rd_addr_q <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      st_cnt_q  <= st_cnt_d;
      rd_addr_q <= rd_addr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      afull_q   <= afull_d;
    end
  end

  assign S_READY = s_ready_q;
  assign COUNT   = count_q;
  assign AFULL   = afull_q;

endmodule
